fetch_stage: RTL and testbench

- Front pipeline stage. Owns the program counter, issues instruction-memory reads and hands (PC, instruction) pairs to the decode stage.
- Uses the decode stage's done/stall handshake and applies the jump redirect that decode raises.
- Holds one outstanding memory request and buffers returned instructions in a 2-entry FIFO, so it sustains 1 instr/cycle against a 1-cycle-latency memory.
- Squashes wrong-path fetches on redirect.

---
 rtl/fetch_stage.sv | 143 ++++++++++++++
 tb/tb_fetch_stage.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_stage.sv
// fetch_stage: front pipeline stage. Owns the PC, issues instruction-memory
// reads (at most one outstanding), and buffers returned instructions in a
// 2-entry FIFO whose head is presented to decode. Decode redirects flush the
// FIFO and squash any in-flight wrong-path response.
module fetch_stage #(
  parameter int                    ADDR_WIDTH        = 32,
  parameter int                    INSTRUCTION_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC          = '0
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         next_stall,
  output logic                         done_next,
  input  logic                         control_flow_affected,
  input  logic [ADDR_WIDTH-1:0]        jump_target,
  input  logic                         jump_target_valid,
  output logic                         imem_req,
  output logic [ADDR_WIDTH-1:0]        imem_addr,
  input  logic                         imem_ready,
  input  logic [INSTRUCTION_WIDTH-1:0] imem_rdata,
  input  logic                         imem_rdata_valid,
  input  logic                         imem_rdata_error,
  output logic [ADDR_WIDTH-1:0]        program_count_out,
  output logic                         program_count_valid_out,
  output logic [INSTRUCTION_WIDTH-1:0] instruction_data_out,
  output logic                         instruction_data_valid_out
);

  typedef struct packed {
    logic [ADDR_WIDTH-1:0]        pc;
    logic [INSTRUCTION_WIDTH-1:0] instr;
    logic                         ok;     // 0 = access fault or misaligned PC
  } entry_t;

  entry_t                  fifo_q [2];
  logic                    rd_ptr, wr_ptr;
  logic [1:0]              fifo_count;

  logic [ADDR_WIDTH-1:0]   fetch_pc;
  logic [ADDR_WIDTH-1:0]   req_pc;      // PC of the request currently in flight
  logic                    outstanding;
  logic                    discard;     // in-flight response belongs to a squashed path
  logic                    halted;      // misaligned entry pushed; wait for redirect

  logic                    redirect, transfer_next, misaligned, accept;
  logic                    resp_push, fault_push, push;
  logic [2:0]              occupancy;
  entry_t                  head, push_entry;

  assign redirect      = control_flow_affected && jump_target_valid;
  assign head          = fifo_q[rd_ptr];
  assign done_next     = !rst && (fifo_count != 2'd0) && !redirect;
  assign transfer_next = done_next && !next_stall;
  assign misaligned    = |fetch_pc[1:0];

  // Slots already claimed (buffered + in flight) after this cycle's pop.
  assign occupancy = {1'b0, fifo_count} + {2'b00, outstanding} - {2'b00, transfer_next};

  assign imem_req  = !rst && !redirect && !halted && !misaligned && (occupancy < 3'd2);
  assign imem_addr = fetch_pc;
  assign accept    = imem_req && imem_ready;

  // Responses arriving during a redirect, or tagged for discard, never land.
  assign resp_push  = imem_rdata_valid && !discard && !redirect;
  // A misaligned PC produces a single faulting entry without touching memory.
  assign fault_push = !rst && misaligned && !halted && !outstanding && !redirect &&
                      !imem_rdata_valid && (fifo_count != 2'd2);
  assign push       = resp_push || fault_push;

  // Select what gets written into the FIFO this cycle.
  always_comb begin
    push_entry = '0;
    if (resp_push) begin
      push_entry.pc    = req_pc;
      push_entry.instr = imem_rdata;
      push_entry.ok    = !imem_rdata_error;
    end else begin
      push_entry.pc    = fetch_pc;
      push_entry.ok    = 1'b0;
    end
  end

  assign program_count_out          = head.pc;
  assign instruction_data_out       = head.instr;
  assign program_count_valid_out    = !rst && (fifo_count != 2'd0);
  assign instruction_data_valid_out = !rst && (fifo_count != 2'd0) && head.ok;

  // FIFO pointers and occupancy; a redirect flushes everything.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr     <= 1'b0;
      wr_ptr     <= 1'b0;
      fifo_count <= 2'd0;
    end else if (redirect) begin
      rd_ptr     <= 1'b0;
      wr_ptr     <= 1'b0;
      fifo_count <= 2'd0;
    end else begin
      if (push)          wr_ptr <= ~wr_ptr;
      if (transfer_next) rd_ptr <= ~rd_ptr;
      fifo_count <= fifo_count + {1'b0, push} - {1'b0, transfer_next};
    end
  end

  // FIFO storage; contents are only meaningful below fifo_count.
  always_ff @(posedge clk) begin
    if (push) fifo_q[wr_ptr] <= push_entry;
  end

  // PC, outstanding/discard tracking and halt on misaligned fetch.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_pc    <= RESET_PC;
      req_pc      <= RESET_PC;
      outstanding <= 1'b0;
      discard     <= 1'b0;
      halted      <= 1'b0;
    end else if (redirect) begin
      fetch_pc <= jump_target;
      halted   <= 1'b0;
      if (imem_rdata_valid) begin
        outstanding <= 1'b0;
        discard     <= 1'b0;
      end else if (outstanding) begin
        discard     <= 1'b1;
      end
    end else begin
      if (accept) begin
        fetch_pc <= fetch_pc + ADDR_WIDTH'(4);
        req_pc   <= fetch_pc;
      end
      if (accept)                outstanding <= 1'b1;
      else if (imem_rdata_valid) outstanding <= 1'b0;
      if (imem_rdata_valid)      discard     <= 1'b0;
      if (fault_push)            halted      <= 1'b1;
    end
  end

  // The issue rule reserves FIFO space for every in-flight request.
  a_no_overflow: assert property (@(posedge clk) disable iff (rst)
    !(push && !transfer_next && fifo_count == 2'd2));

endmodule

// File: tb/tb_fetch_stage.sv
// Scoreboard bench for fetch_stage: stimulus queues the expected (PC, instr,
// valid) stream, a monitor pops and compares on each decode transfer.
module tb_fetch_stage;

  logic        clk, rst;
  logic        next_stall, done_next;
  logic        cfa, jtv;
  logic [31:0] jt;
  logic        imem_req, imem_ready, imem_rdata_valid, imem_rdata_error;
  logic [31:0] imem_addr, imem_rdata;
  logic [31:0] pc_out, ins_out;
  logic        pcv, idv;

  fetch_stage #(.ADDR_WIDTH(32), .INSTRUCTION_WIDTH(32), .RESET_PC(32'h0)) dut (
    .clk(clk), .rst(rst), .next_stall(next_stall), .done_next(done_next),
    .control_flow_affected(cfa), .jump_target(jt), .jump_target_valid(jtv),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ready(imem_ready),
    .imem_rdata(imem_rdata), .imem_rdata_valid(imem_rdata_valid),
    .imem_rdata_error(imem_rdata_error),
    .program_count_out(pc_out), .program_count_valid_out(pcv),
    .instruction_data_out(ins_out), .instruction_data_valid_out(idv)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] ins;
    logic        iv;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] acc_addr[$];
  int          acc_cyc[$];
  int          errors = 0, checks = 0, cyc_n = 0;
  int          lat;
  logic [31:0] err_addr;

  // Memory model: one request at a time, fixed latency, ready again on the
  // cycle its response is returned.
  logic        m_busy;
  int          m_cnt;
  logic [31:0] m_addr;
  assign imem_rdata_valid = m_busy && (m_cnt == 0);
  assign imem_ready       = !m_busy || (m_cnt == 0);
  assign imem_rdata       = m_addr ^ 32'hC0DE_0000;
  assign imem_rdata_error = (m_addr == err_addr);

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_busy <= 1'b0;
      m_cnt  <= 0;
      m_addr <= 32'h0;
    end else if (imem_req && imem_ready) begin
      m_busy <= 1'b1;
      m_cnt  <= lat - 1;
      m_addr <= imem_addr;
    end else if (m_busy) begin
      if (m_cnt == 0) m_busy <= 1'b0;
      else            m_cnt  <= m_cnt - 1;
    end
  end

  always @(posedge clk) cyc_n <= cyc_n + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic exp_t mk(input logic [31:0] pc);
    exp_t e;
    e.pc  = pc;
    e.ins = pc ^ 32'hC0DE_0000;
    e.iv  = (pc != err_addr) && (pc[1:0] == 2'b00);
    return e;
  endfunction

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  // Queue n sequential expectations from pc0 and let decode take exactly n.
  task automatic consume(input logic [31:0] pc0, input int n, output int cyc);
    int got;
    got = 0;
    cyc = 0;
    for (int i = 0; i < n; i++) exp_q.push_back(mk(pc0 + 32'(4 * i)));
    while (got < n && cyc < 60) begin
      tick();
      cyc++;
      if (done_next) begin
        next_stall = 1'b0;
        got++;
      end else begin
        next_stall = 1'b1;
      end
    end
    if (got < n) begin
      checks++;
      errors++;
      $display("FAIL consume_timeout: got %0d transfers expected %0d", got, n);
    end
    tick();
    next_stall = 1'b1;
  endtask

  // Monitor: log accepted requests and check every transfer against the queue.
  always begin
    exp_t e;
    @(negedge clk);
    #3;
    if (!rst && imem_req && imem_ready) begin
      acc_addr.push_back(imem_addr);
      acc_cyc.push_back(cyc_n);
    end
    if (done_next && !next_stall) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_pop: got pc %h expected no transfer", pc_out);
      end else begin
        e = exp_q.pop_front();
        chk("pop_pc", pc_out, e.pc);
        chk("pop_pcv", {31'b0, pcv}, 32'd1);
        chk("pop_ival", {31'b0, idv}, {31'b0, e.iv});
        if (e.iv) chk("pop_instr", ins_out, e.ins);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int c;
    rst = 1'b1; next_stall = 1'b1; cfa = 1'b0; jtv = 1'b0; jt = 32'h0;
    lat = 1; err_addr = 32'hFFFF_FFFF;
    repeat (2) tick();
    chk("rst_done", {31'b0, done_next}, 32'd0);
    chk("rst_req",  {31'b0, imem_req},  32'd0);
    chk("rst_pcv",  {31'b0, pcv},       32'd0);
    chk("rst_idv",  {31'b0, idv},       32'd0);
    rst = 1'b0;

    // Streaming start, then decode stalls for 5 cycles.
    consume(32'h0, 1, c);
    repeat (5) tick();
    chk("stall_req",  {31'b0, imem_req},  32'd0);
    chk("stall_done", {31'b0, done_next}, 32'd1);
    chk("stall_head", pc_out, 32'h4);
    chk("acc_count_ge3", {31'b0, acc_addr.size() >= 3}, 32'd1);
    if (acc_addr.size() >= 3) begin
      chk("acc0", acc_addr[0], 32'h0);
      chk("acc1", acc_addr[1], 32'h4);
      chk("acc2", acc_addr[2], 32'h8);
      chk("acc_b2b", 32'(acc_cyc[2] - acc_cyc[0]), 32'd2);
    end
    consume(32'h4, 2, c);
    chk("pop_b2b_cycles", 32'(c), 32'd2);

    // Redirect with a latency-3 request in flight: its response must vanish.
    lat = 3;
    consume(32'hC, 2, c);
    cfa = 1'b1; jtv = 1'b1; jt = 32'h100;
    #1;
    chk("redir_done", {31'b0, done_next}, 32'd0);
    chk("redir_req",  {31'b0, imem_req},  32'd0);
    tick();
    cfa = 1'b0; jtv = 1'b0;
    consume(32'h100, 1, c);

    // Redirect held for three cycles.
    lat = 1;
    cfa = 1'b1; jtv = 1'b1; jt = 32'h200;
    for (int k = 0; k < 3; k++) begin
      if (k > 0) tick();
      #1;
      chk("hold_done", {31'b0, done_next}, 32'd0);
      chk("hold_req",  {31'b0, imem_req},  32'd0);
      if (k > 0) chk("hold_pcv", {31'b0, pcv}, 32'd0);
    end
    tick();
    cfa = 1'b0; jtv = 1'b0;
    #1;
    chk("post_hold_req",  {31'b0, imem_req}, 32'd1);
    chk("post_hold_addr", imem_addr, 32'h200);

    // Faulting response at 0x208; a redirect without a valid target is ignored.
    err_addr = 32'h208;
    cfa = 1'b1; jtv = 1'b0; jt = 32'h999;
    consume(32'h200, 4, c);
    cfa = 1'b0;

    // Redirect to a misaligned target while the FIFO is full.
    repeat (3) tick();
    chk("pre_mis_pcv", {31'b0, pcv}, 32'd1);
    cfa = 1'b1; jtv = 1'b1; jt = 32'h102;
    #1;
    chk("redir_full_done", {31'b0, done_next}, 32'd0);
    tick();
    cfa = 1'b0; jtv = 1'b0;
    consume(32'h102, 1, c);
    for (int k = 0; k < 5; k++) begin
      tick();
      chk("halted", {30'b0, done_next, imem_req}, 32'd0);
    end

    // Resume at 0x300, then reset with a request in flight.
    cfa = 1'b1; jtv = 1'b1; jt = 32'h300;
    tick();
    cfa = 1'b0; jtv = 1'b0;
    repeat (4) tick();
    lat = 3;
    consume(32'h300, 1, c);
    #1;
    chk("pre_rst_pcv", {31'b0, pcv}, 32'd1);
    chk("pre_rst_idv", {31'b0, idv}, 32'd1);
    rst = 1'b1;
    #1;
    chk("async_rst_done", {31'b0, done_next}, 32'd0);
    chk("async_rst_req",  {31'b0, imem_req},  32'd0);
    chk("async_rst_pcv",  {31'b0, pcv},       32'd0);
    chk("async_rst_idv",  {31'b0, idv},       32'd0);
    tick();
    tick();
    rst = 1'b0;
    consume(32'h0, 2, c);

    tick();
    chk("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
